// File: rtl/exec_wb_pkg.sv
// exec_wb_pkg: shared definitions for the execute/writeback controller.
//   - RV opcode[6:0] values handled by the controller
//   - LOAD/STORE funct3 width codes
//   - controller state encoding
//   - width_legal(): funct3 legality check for a LOAD or STORE
package exec_wb_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // funct3[1:0] is log2 of the access size in bytes; funct3[2] selects zero-extension.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // EXEC is the decode cycle between accept and MEM/WB, giving the
  // two-cycle busy window of a non-memory instruction.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Doubleword accesses and LWU only exist on a 64-bit datapath.
  function automatic logic width_legal(input logic       store,
                                       input logic [2:0] f3,
                                       input logic       rv64);
    if (store) return (f3 inside {F3_B, F3_H, F3_W}) || (rv64 && f3 == F3_D);
    return (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
           (rv64 && (f3 == F3_D || f3 == F3_WU));
  endfunction

endpackage

// File: rtl/exec_wb_ctrl_load_align.sv
// load_align: combinational load-lane extraction.
//   rdata  in  XLEN     aligned memory word
//   offset in  log2(XLEN/8)  byte offset of the access inside the word
//   funct3 in  3        load width/sign selector
//   data   out XLEN     extracted lane, sign- or zero-extended to XLEN
module load_align
  import exec_wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] lane;

  // Move the addressed byte lane down to bit 0.
  assign lane = rdata >> {offset, 3'b000};

  // A size cast of a signed operand sign-extends; of an unsigned one, zero-extends.
  always_comb begin
    // NOTE: assign a default before the case so no path leaves data unassigned (no latch).
    data = '0;
    case (funct3)
      F3_B:    data = XLEN'($signed(lane[7:0]));
      F3_H:    data = XLEN'($signed(lane[15:0]));
      F3_W:    data = XLEN'($signed(lane[31:0]));
      F3_BU:   data = XLEN'(lane[7:0]);
      F3_HU:   data = XLEN'(lane[15:0]);
      F3_WU:   data = XLEN'(lane[31:0]);
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/exec_wb_ctrl.sv
// exec_wb_ctrl: multi-cycle execute/writeback controller for an RV32/RV64I core.
//   Handshake : in_valid/in_ready (ready only in IDLE), instruction fields opcode,
//               funct3, rs1_input, rs2_input, imm, pc_input, alu_output, br_taken.
//   Memory    : mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb out, mem_ack/mem_rdata in.
//   Writeback : rd_we/rd_data, j_signal/jump, illegal, bus_err, misalign (WB pulses).
// Parameters: XLEN (32/64), MEM_TIMEOUT (MEM cycles before bus_err, 0 = never).
// Build option: define MISALIGN_TRAP_EN to trap misaligned accesses; otherwise
// the address is aligned down to the access size and misalign stays 0.
module exec_wb_ctrl
  import exec_wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_input,
  input  logic [XLEN-1:0]   rs2_input,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc_input,
  input  logic [XLEN-1:0]   alu_output,
  input  logic              br_taken,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rd_we,
  output logic [XLEN-1:0]   rd_data,
  output logic              j_signal,
  output logic [XLEN-1:0]   jump,
  output logic              illegal,
  output logic              bus_err,
  output logic              misalign
);

  localparam int STRB = XLEN / 8;
  localparam int OFFW = $clog2(STRB);

  state_t state, state_nxt;

  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q, alu_q, rdata_q;
  logic            br_q, tmo_q;
  logic [31:0]     tmo_cnt;

  logic            accept, is_load, is_store, is_mem, known_op, width_ok;
  logic            illegal_c, misalign_c, tmo_hit;
  logic [XLEN-1:0] eff_addr, acc_addr, jalr_sum, load_data, st_wdata;
  logic [OFFW-1:0] off_mask;
  logic [STRB-1:0] st_wstrb;

  assign accept   = in_valid && in_ready;
  assign is_load  = (op_q == LOAD);
  assign is_store = (op_q == STORE);
  assign is_mem   = is_load || is_store;
  assign known_op = op_q inside {OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR};
  assign width_ok = width_legal(is_store, f3_q, XLEN == 64);
  assign illegal_c = !known_op || (is_mem && !width_ok);
  assign eff_addr = rs1_q + imm_q;
  assign jalr_sum = rs1_q + imm_q;
  assign tmo_hit  = (MEM_TIMEOUT != 0) && !mem_ack && (tmo_cnt == 32'(MEM_TIMEOUT - 1));

  // Address bits below the access size.
  always_comb begin
    off_mask = '0;
    case (f3_q[1:0])
      2'b00:   off_mask = '0;
      2'b01:   off_mask = OFFW'(1);
      2'b10:   off_mask = OFFW'(3);
      default: off_mask = '1;
    endcase
  end

  // Aligned-down access address; identical to eff_addr for aligned accesses.
  assign acc_addr = {eff_addr[XLEN-1:OFFW], eff_addr[OFFW-1:0] & ~off_mask};

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = is_mem && width_ok && (|(eff_addr[OFFW-1:0] & off_mask));
`else
  assign misalign_c = 1'b0;
`endif

  // Store data replicated into every lane of its size; strobes select the addressed lane.
  always_comb begin
    st_wdata = rs2_q;
    st_wstrb = '1;
    case (f3_q[1:0])
      2'b00: begin
        st_wdata = {(XLEN/8){rs2_q[7:0]}};
        st_wstrb = STRB'(1) << acc_addr[OFFW-1:0];
      end
      2'b01: begin
        st_wdata = {(XLEN/16){rs2_q[15:0]}};
        st_wstrb = STRB'(3) << acc_addr[OFFW-1:0];
      end
      2'b10: begin
        st_wdata = {(XLEN/32){rs2_q[31:0]}};
        st_wstrb = STRB'(15) << acc_addr[OFFW-1:0];
      end
      default: begin
        st_wdata = rs2_q;
        st_wstrb = '1;
      end
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (rdata_q),
    .offset (acc_addr[OFFW-1:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // State register. Asynchronous reset returns to IDLE at once, dropping mem_req.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is always written with non-blocking assignments.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = (is_mem && !illegal_c && !misalign_c) ? ST_MEM : ST_WB;
      ST_MEM:  if (mem_ack || tmo_hit) state_nxt = ST_WB;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Instruction fields, captured load data and the MEM timeout tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= '0;
      f3_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      br_q    <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (accept) begin
        op_q  <= opcode;
        f3_q  <= funct3;
        rs1_q <= rs1_input;
        rs2_q <= rs2_input;
        imm_q <= imm;
        pc_q  <= pc_input;
        alu_q <= alu_output;
        br_q  <= br_taken;
      end
      if (state == ST_EXEC) begin
        tmo_cnt <= '0;
        tmo_q   <= 1'b0;
      end
      if (state == ST_MEM) begin
        if (mem_ack)      rdata_q <= mem_rdata;
        else if (tmo_hit) tmo_q   <= 1'b1;
        else              tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    rd_we     = 1'b0;
    rd_data   = '0;
    j_signal  = 1'b0;
    jump      = '0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    misalign  = 1'b0;
    case (state)
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_addr = acc_addr;
        if (is_store) begin
          mem_wdata = st_wdata;
          mem_wstrb = st_wstrb;
        end
      end
      ST_WB: begin
        if (illegal_c)       illegal  = 1'b1;
        else if (misalign_c) misalign = 1'b1;
        else begin
          case (op_q)
            OP, OP_IMM: begin rd_we = 1'b1; rd_data = alu_q; end
            LUI:        begin rd_we = 1'b1; rd_data = imm_q; end
            AUIPC:      begin rd_we = 1'b1; rd_data = pc_q + imm_q; end
            JAL: begin
              rd_we = 1'b1; rd_data = pc_q + XLEN'(4);
              j_signal = 1'b1; jump = pc_q + imm_q;
            end
            JALR: begin
              rd_we = 1'b1; rd_data = pc_q + XLEN'(4);
              j_signal = 1'b1; jump = jalr_sum & ~XLEN'(1);
            end
            BRANCH: begin j_signal = br_q; jump = pc_q + imm_q; end
            LOAD: begin
              if (tmo_q) bus_err = 1'b1;
              else begin rd_we = 1'b1; rd_data = load_data; end
            end
            default: bus_err = tmo_q;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exec_wb_ctrl.sv
// tb_exec_wb_ctrl: scoreboard bench for exec_wb_ctrl (XLEN=32, MEM_TIMEOUT=16,
// aligned-down build). The driver pushes model-derived expectations; a memory
// responder and a writeback monitor pop and compare them independently.
module tb_exec_wb_ctrl;

  localparam int XLEN        = 32;
  localparam int MEM_TIMEOUT = 16;
  localparam int NEVER       = -1;

  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_OPI   = 7'h13;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] rs1_input, rs2_input, imm, pc_input, alu_output;
  logic        br_taken;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rd_we, j_signal, illegal, bus_err, misalign;
  logic [31:0] rd_data, jump;

  exec_wb_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rs1_input(rs1_input), .rs2_input(rs2_input),
    .imm(imm), .pc_input(pc_input), .alu_output(alu_output), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rd_we(rd_we), .rd_data(rd_data), .j_signal(j_signal), .jump(jump),
    .illegal(illegal), .bus_err(bus_err), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm, pc, alu, rdata;
    logic        br;
    int          delay;
  } txn_t;

  typedef struct {
    logic        rd_we;
    logic [31:0] rd_data;
    logic        j;
    logic [31:0] jump;
    logic        ill, berr, mis;
    int          cycles;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          delay;
    logic [31:0] rdata;
  } mreq_t;

  wb_t   exp_wb_q[$];
  mreq_t exp_mem_q[$];
  int    checks = 0;
  int    errors = 0;
  int    idle_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural result of one instruction from the ISA rules.
  function automatic void model(input txn_t t, output wb_t w, output mreq_t m, output bit has_mem);
    logic [31:0] ea;
    int          sz, idx;
    longint      span, val;
    bit          legal, is_ld, is_st;
    w = '{default: 0};
    m = '{default: 0};
    has_mem  = 0;
    w.cycles = 2;
    is_ld = (t.op == OPC_LOAD);
    is_st = (t.op == OPC_STORE);
    legal = t.op inside {OPC_OP, OPC_OPI, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE,
                         OPC_BR, OPC_JAL, OPC_JALR};
    if (is_ld) legal = t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (is_st) legal = t.f3 inside {3'd0, 3'd1, 3'd2};
    if (!legal) begin
      w.ill = 1;
      return;
    end
    case (t.op)
      OPC_OP, OPC_OPI: begin w.rd_we = 1; w.rd_data = t.alu; end
      OPC_LUI:         begin w.rd_we = 1; w.rd_data = t.imm; end
      OPC_AUIPC:       begin w.rd_we = 1; w.rd_data = t.pc + t.imm; end
      OPC_JAL: begin
        w.rd_we = 1; w.rd_data = t.pc + 32'd4; w.j = 1; w.jump = t.pc + t.imm;
      end
      OPC_JALR: begin
        w.rd_we = 1; w.rd_data = t.pc + 32'd4; w.j = 1;
        w.jump = (t.rs1 + t.imm) & 32'hFFFF_FFFE;
      end
      OPC_BR: begin w.j = t.br; w.jump = t.pc + t.imm; end
      default: begin
        sz   = 1 << (t.f3 % 4);
        ea   = t.rs1 + t.imm;
        ea   = ea - (ea % 32'(sz));
        idx  = int'(ea % 32'd4);
        span = longint'(1) << (8 * sz);
        has_mem  = 1;
        m.we     = is_st;
        m.addr   = ea;
        m.delay  = t.delay;
        m.rdata  = t.rdata;
        w.cycles = (t.delay == NEVER) ? MEM_TIMEOUT + 2 : t.delay + 3;
        if (t.delay == NEVER) w.berr = 1;
        else if (is_ld) begin
          val = (longint'(t.rdata) >> (8 * idx)) % span;
          if (t.f3 < 3'd4 && val >= span / 2) val = val - span;
          w.rd_we   = 1;
          w.rd_data = val[31:0];
        end
        if (is_st) begin
          m.strb = 4'(((1 << sz) - 1) << idx);
          for (int i = 0; i < 4 / sz; i++)
            m.wdata = m.wdata | 32'((longint'(t.rs2) % span) << (8 * sz * i));
        end
      end
    endcase
  endfunction

  function automatic txn_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [31:0] im, input logic [31:0] pc,
                              input logic [31:0] alu, input logic br,
                              input int delay, input logic [31:0] rdata);
    txn_t t;
    t.op = op; t.f3 = f3; t.rs1 = rs1; t.rs2 = rs2; t.imm = im; t.pc = pc;
    t.alu = alu; t.br = br; t.delay = delay; t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t        t;
    logic [6:0]  ops [9] = '{OPC_OP, OPC_OPI, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                             OPC_STORE, OPC_BR, OPC_JAL, OPC_JALR};
    logic [11:0] r12;
    int          sel;
    sel = $urandom_range(0, 13);
    if (sel < 9)       t.op = ops[sel];
    else if (sel < 11) t.op = (sel == 9) ? OPC_LOAD : OPC_STORE;
    else if (sel < 13) t.op = (sel == 11) ? OPC_LOAD : OPC_STORE;
    else begin
      do t.op = 7'($urandom);
      while (t.op inside {OPC_OP, OPC_OPI, OPC_LUI, OPC_AUIPC, OPC_LOAD,
                          OPC_STORE, OPC_BR, OPC_JAL, OPC_JALR});
    end
    r12     = 12'($urandom);
    t.f3    = 3'($urandom);
    t.rs1   = $urandom;
    t.rs2   = $urandom;
    t.imm   = {{20{r12[11]}}, r12};
    t.pc    = $urandom;
    t.alu   = $urandom;
    t.br    = 1'($urandom);
    t.rdata = $urandom;
    t.delay = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 4));
    return t;
  endfunction

  task automatic scramble_inputs();
    opcode     = 7'($urandom);
    funct3     = 3'($urandom);
    rs1_input  = $urandom;
    rs2_input  = $urandom;
    imm        = $urandom;
    pc_input   = $urandom;
    alu_output = $urandom;
    br_taken   = 1'($urandom);
  endtask

  // Waits (bounded) for in_ready, presents the instruction for one accept edge,
  // then scrambles the fields to show they are ignored while busy.
  task automatic issue(input txn_t t, input bit expect_wb);
    wb_t   w;
    mreq_t m;
    bit    hm, ok;
    model(t, w, m, hm);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: in_ready stayed 0, required 1 within 300 cycles");
      return;
    end
    if (expect_wb) exp_wb_q.push_back(w);
    if (hm) exp_mem_q.push_back(m);
    in_valid = 1'b1; opcode = t.op; funct3 = t.f3; rs1_input = t.rs1; rs2_input = t.rs2;
    imm = t.imm; pc_input = t.pc; alu_output = t.alu; br_taken = t.br;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Memory responder: checks every MEM cycle against the expected request, acks after the chosen delay.
  initial begin : responder
    mreq_t cur;
    bit    active;
    int    mcnt;
    cur = '{default: 0};
    active = 0;
    mcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (!rst || !mem_req) active = 0;
      else begin
        if (!active) begin
          active = 1;
          mcnt = 0;
          if (exp_mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected: mem_req=1 with addr 0x%0h, required no request", mem_addr);
            cur = '{default: 0};
          end else cur = exp_mem_q.pop_front();
        end
        check("mem_we",    mem_we,    cur.we);
        check("mem_addr",  mem_addr,  cur.addr);
        check("mem_wdata", mem_wdata, cur.wdata);
        check("mem_wstrb", mem_wstrb, cur.strb);
        if (cur.delay != NEVER && mcnt == cur.delay) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
        end
        mcnt++;
      end
    end
  end

  // Writeback monitor: a busy window ends when in_ready returns; its last cycle is WB.
  initial begin : monitor
    wb_t  e;
    int   busy, pulses;
    logic l_rd_we, l_j, l_ill, l_berr, l_mis, any;
    logic [31:0] l_rd_data, l_jump;
    busy = 0; pulses = 0;
    l_rd_we = 0; l_j = 0; l_ill = 0; l_berr = 0; l_mis = 0; l_rd_data = '0; l_jump = '0;
    forever begin
      @(negedge clk);
      any = rd_we | j_signal | illegal | bus_err | misalign;
      if (!rst) begin
        busy = 0; pulses = 0;
      end else if (!in_ready) begin
        busy++;
        pulses += int'(any);
        l_rd_we = rd_we; l_rd_data = rd_data; l_j = j_signal; l_jump = jump;
        l_ill = illegal; l_berr = bus_err; l_mis = misalign;
      end else begin
        if (any) idle_pulses++;
        if (busy > 0) begin
          if (exp_wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: busy window of %0d cycles, required none", busy);
          end else begin
            e = exp_wb_q.pop_front();
            check("wb_busy_cycles", busy, e.cycles);
            check("wb_pulse_cycles", pulses, (e.rd_we | e.j | e.ill | e.berr | e.mis) ? 1 : 0);
            check("wb_rd_we", l_rd_we, e.rd_we);
            if (e.rd_we) check("wb_rd_data", l_rd_data, e.rd_data);
            check("wb_j_signal", l_j, e.j);
            if (e.j) check("wb_jump", l_jump, e.jump);
            check("wb_illegal", l_ill, e.ill);
            check("wb_bus_err", l_berr, e.berr);
            check("wb_misalign", l_mis, e.mis);
          end
          busy = 0; pulses = 0;
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    in_valid = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req",  mem_req,  0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rd_we",    rd_we,    0);
    check("rst_rd_data",  rd_data,  0);
    check("rst_j_signal", j_signal, 0);
    check("rst_jump",     jump,     0);
    check("rst_flags",    {illegal, bus_err, misalign}, 0);
    rst = 1'b1;

    issue(mk(OPC_OP,    3'd0, 32'd0,     32'd0,       32'd0,        32'd0,        32'd10, 1'b0, 0, 32'd0), 1);
    issue(mk(OPC_LOAD,  3'd2, 32'd13,    32'd0,       32'd1,        32'd0,        32'd0,  1'b0, 2, 32'h3ffff), 1);
    issue(mk(OPC_LOAD,  3'd0, 32'h100,   32'd0,       32'd1,        32'd0,        32'd0,  1'b0, 0, 32'h80FF), 1);
    issue(mk(OPC_LOAD,  3'd4, 32'h100,   32'd0,       32'd1,        32'd0,        32'd0,  1'b0, 1, 32'h80FF), 1);
    issue(mk(OPC_STORE, 3'd1, 32'h100,   32'h3ffff,   32'd2,        32'd0,        32'd0,  1'b0, 1, 32'd0), 1);
    issue(mk(OPC_BR,    3'd0, 32'd0,     32'd0,       32'd1,        32'd10,       32'd0,  1'b1, 0, 32'd0), 1);
    issue(mk(OPC_BR,    3'd0, 32'd0,     32'd0,       32'd1,        32'd10,       32'd0,  1'b0, 0, 32'd0), 1);
    issue(mk(OPC_JALR,  3'd0, 32'd10,    32'd0,       32'd1,        32'h20,       32'd0,  1'b0, 0, 32'd0), 1);
    issue(mk(OPC_JAL,   3'd0, 32'd0,     32'd0,       32'd8,        32'hFFFF_FFFC, 32'd0, 1'b0, 0, 32'd0), 1);
    issue(mk(OPC_LUI,   3'd0, 32'd0,     32'd0,       32'h1234_5000, 32'd0,       32'd0,  1'b0, 0, 32'd0), 1);
    issue(mk(OPC_AUIPC, 3'd0, 32'd0,     32'd0,       32'hF000_0000, 32'h2000_0004, 32'd0, 1'b0, 0, 32'd0), 1);
    issue(mk(OPC_LOAD,  3'd2, 32'h40,    32'd0,       32'd0,        32'd0,        32'd0,  1'b0, NEVER, 32'd0), 1);
    issue(mk(OPC_STORE, 3'd2, 32'h44,    32'h55AA,    32'd0,        32'd0,        32'd0,  1'b0, NEVER, 32'd0), 1);
    issue(mk(7'h7F,     3'd0, 32'd0,     32'd0,       32'd0,        32'd0,        32'd0,  1'b0, 0, 32'd0), 1);
    issue(mk(OPC_LOAD,  3'd3, 32'h80,    32'd0,       32'd0,        32'd0,        32'd0,  1'b0, 0, 32'd0), 1);
    issue(mk(OPC_STORE, 3'd3, 32'h80,    32'd0,       32'd0,        32'd0,        32'd0,  1'b0, 0, 32'd0), 1);

    // Reset while a request is outstanding must drop mem_req without a clock edge.
    issue(mk(OPC_LOAD, 3'd2, 32'h200, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, NEVER, 32'd0), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_mem_req",  mem_req,  0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    #1 rst = 1'b1;

    for (int n = 0; n < 250; n++) issue(rnd_txn(), 1);

    for (int i = 0; i < 500 && (exp_wb_q.size() != 0 || exp_mem_q.size() != 0); i++)
      @(negedge clk);
    check("wb_queue_drained",  exp_wb_q.size(),  0);
    check("mem_queue_drained", exp_mem_q.size(), 0);
    check("idle_pulses", idle_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
